ad_buf_reader: RTL and testbench

- Read-side counterpart of the AD capture path.
- After the capture writer has filled the 512-entry sample RAM, this block reads addresses 0..511 in order.
- It streams each sample downstream (to the UART/display path) over a valid/ready handshake.
- In the same pass it computes the cable-fault echo position (first threshold crossing after a blanking window) and the peak sample value and address.

---
 rtl/ad_buf_reader.sv | 249 ++++++++++++++++++++++++
 tb/tb_ad_buf_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_buf_reader.sv
// ---------------------------------------------------------------------------
// ad_buf_reader
//
// Read side of the AD capture path. Once the capture writer has filled the
// sample RAM, a single start pulse launches one read pass over every address
// from 0 to DEPTH-1, in order. Each sample goes downstream (UART/display path)
// over a valid/ready handshake. While the samples stream past, the block also
// works out two results for the pass:
//   - the cable-fault echo: the first address at or beyond the blanking window
//     whose sample is >= the threshold latched at start
//   - the peak sample value and the address where it first occurs
//
// Handshake (sample_out / sample_addr / sample_valid / sample_ready):
//   A transfer happens on a rising clk_30M edge where sample_valid and
//   sample_ready are both high. Once sample_valid is raised, sample_out and
//   sample_addr stay unchanged until that transfer happens. sample_valid is
//   never withdrawn without a transfer. sample_ready may be high before
//   sample_valid. While sample_valid is low, sample_ready is ignored.
//
// Ports:
//   clk_30M       in   system clock, shared with the capture path
//   sys_rst_n     in   asynchronous active-low reset
//   start         in   one-cycle pulse: capture complete, begin a read pass
//   thresh        in   echo threshold, latched when start is accepted
//   ram_rd_en     out  RAM read enable (one cycle per sample)
//   addr_rd       out  RAM read address
//   ram_rd_data   in   RAM read data, valid RD_LAT cycles after ram_rd_en
//   sample_out    out  streamed sample
//   sample_addr   out  address of sample_out
//   sample_valid  out  sample_out / sample_addr valid
//   sample_ready  in   downstream accepts the sample
//   busy          out  read pass in progress
//   done          out  one-cycle pulse when the pass completes
//   echo_found    out  an echo was detected in the last pass
//   echo_addr     out  address of the first echo sample
//   peak_val      out  largest sample of the last pass
//   peak_addr     out  earliest address holding peak_val
//   fsm_state     out  debug view of the sequencer state (encoding below)
// ---------------------------------------------------------------------------
module ad_buf_reader #(
    parameter int ADDR_W = 9,  // RAM address width, depth = 2**ADDR_W
    parameter int DATA_W = 8,  // sample width
    parameter int RD_LAT = 1,  // RAM read latency in cycles (1 or 2)
    parameter int BLANK  = 8   // leading addresses that can never be an echo
) (
    input  logic              clk_30M,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] thresh,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] sample_out,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              echo_found,
    output logic [ADDR_W-1:0] echo_addr,
    output logic [DATA_W-1:0] peak_val,
    output logic [ADDR_W-1:0] peak_addr,
    output logic [2:0]        fsm_state
);

    // Sequencer states. The encoding is visible on fsm_state.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,  // waiting for start
        S_FETCH   = 3'd1,  // issue one RAM read
        S_WAIT    = 3'd2,  // wait for the RAM read latency
        S_PRESENT = 3'd3,  // offer the sample until accepted
        S_DONE    = 3'd4   // one-cycle completion pulse
    } state_t;

    // The latency counter is loaded with RD_LAT and the sample is captured
    // when it reaches 1, so the wait lasts exactly RD_LAT cycles.
    localparam logic [1:0]        LAT_INIT  = 2'(RD_LAT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] BLANK_A   = ADDR_W'(BLANK);

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   rd_cnt;     // address of the sample being handled
    logic [1:0]          lat_cnt;    // remaining RAM latency cycles
    logic [DATA_W-1:0]   thresh_q;   // threshold latched at accepted start

    logic                handshake;  // sample transfer on this edge
    logic                lat_done;   // RAM data is valid on this cycle
    logic                last_addr;  // presented sample is the final one
    logic                new_peak;   // accepted sample becomes the peak
    logic                new_echo;   // accepted sample is the first echo

    // -----------------------------------------------------------------------
    // Condition decode
    // -----------------------------------------------------------------------
    always_comb begin
        handshake = 1'b0;
        lat_done  = 1'b0;
        last_addr = 1'b0;
        new_peak  = 1'b0;
        new_echo  = 1'b0;

        // sample_valid is only ever high in S_PRESENT, so ready with valid
        // low has no effect here.
        handshake = sample_valid && sample_ready;
        lat_done  = (lat_cnt == 2'd1);
        last_addr = (sample_addr == LAST_ADDR);

        // Address 0 always seeds the peak, so results from an earlier pass
        // can never leak in. A strict greater-than keeps the earliest address
        // when values tie.
        new_peak = (sample_out > peak_val) || (sample_addr == '0);

        // The first crossing wins. Later crossings are ignored once
        // echo_found is set. The transmit pulse region is excluded.
        new_echo = !echo_found && (sample_addr >= BLANK_A) &&
                   (sample_out >= thresh_q);
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_30M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and Moore outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ram_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                // start is only looked at here. A start while busy, or in
                // the same cycle as done, is dropped.
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                ram_rd_en = 1'b1;
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (lat_done) begin
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                busy = 1'b1;
                if (handshake) begin
                    state_nxt = last_addr ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                // busy stays high through the done cycle. It is low from
                // the next cycle, when the block is back in S_IDLE.
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The counter only moves after a transfer, so the read address and the
    // presented address always agree.
    assign addr_rd   = rd_cnt;
    assign fsm_state = state;

    // -----------------------------------------------------------------------
    // Datapath: address/latency counters, sample register, pass results
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_30M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_cnt       <= '0;
            lat_cnt      <= '0;
            thresh_q     <= '0;
            sample_out   <= '0;
            sample_addr  <= '0;
            sample_valid <= 1'b0;
            echo_found   <= 1'b0;
            echo_addr    <= '0;
            peak_val     <= '0;
            peak_addr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Results of the previous pass stay visible until a new
                    // pass really starts.
                    if (start) begin
                        thresh_q   <= thresh;
                        rd_cnt     <= '0;
                        echo_found <= 1'b0;
                        echo_addr  <= '0;
                        peak_val   <= '0;
                        peak_addr  <= '0;
                    end
                end
                S_FETCH: begin
                    lat_cnt <= LAT_INIT;
                end
                S_WAIT: begin
                    if (lat_done) begin
                        sample_out   <= ram_rd_data;
                        sample_addr  <= rd_cnt;
                        sample_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (handshake) begin
                        sample_valid <= 1'b0;
                        if (new_peak) begin
                            peak_val  <= sample_out;
                            peak_addr <= sample_addr;
                        end
                        if (new_echo) begin
                            echo_found <= 1'b1;
                            echo_addr  <= sample_addr;
                        end
                        // The pass ends at the last address. The counter is
                        // never allowed to wrap.
                        if (!last_addr) begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad_buf_reader.sv
module tb_ad_buf_reader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int BLANK  = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LIMIT  = 20000;

    // ---------------------------------------------------------------- clock
    logic              clk_30M = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] thresh = '0;
    logic              sample_ready = 1'b0;
    logic [DATA_W-1:0] ram_rd_data = '0;

    logic              ram_rd_en;
    logic [ADDR_W-1:0] addr_rd;
    logic [DATA_W-1:0] sample_out;
    logic [ADDR_W-1:0] sample_addr;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic              echo_found;
    logic [ADDR_W-1:0] echo_addr;
    logic [DATA_W-1:0] peak_val;
    logic [ADDR_W-1:0] peak_addr;
    logic [2:0]        fsm_state;

    always #5 clk_30M = ~clk_30M;

    ad_buf_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BLANK(BLANK)
    ) dut (
        .clk_30M     (clk_30M),
        .sys_rst_n   (sys_rst_n),
        .start       (start),
        .thresh      (thresh),
        .ram_rd_en   (ram_rd_en),
        .addr_rd     (addr_rd),
        .ram_rd_data (ram_rd_data),
        .sample_out  (sample_out),
        .sample_addr (sample_addr),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy        (busy),
        .done        (done),
        .echo_found  (echo_found),
        .echo_addr   (echo_addr),
        .peak_val    (peak_val),
        .peak_addr   (peak_addr),
        .fsm_state   (fsm_state)
    );

    // Sample RAM with a single-cycle registered read.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk_30M) begin
        if (ram_rd_en) ram_rd_data <= mem[addr_rd];
    end

    // ------------------------------------------------------------ scoreboard
    int                       n_vec = 0;
    int                       n_err = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int                       seen;
    int                       done_cnt = 0;
    int                       rdy_mode = 0;
    bit                       hold_prev;
    logic [DATA_W-1:0]        hold_d;
    logic [ADDR_W-1:0]        hold_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called once per negedge while a pass is running.
    task automatic monitor();
        logic [ADDR_W+DATA_W-1:0] e;
        if (hold_prev) begin
            chk("hold_valid", 32'(sample_valid), 32'd1);
            chk("hold_data", 32'(sample_out), 32'(hold_d));
            chk("hold_addr", 32'(sample_addr), 32'(hold_a));
        end
        if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_sample: got addr %0d, no sample expected", sample_addr);
            end else begin
                e = exp_q.pop_front();
                chk("stream_addr", 32'(sample_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                chk("stream_data", 32'(sample_out), 32'(e[DATA_W-1:0]));
            end
            seen++;
        end
        hold_prev = sample_valid && !sample_ready;
        hold_d    = sample_out;
        hold_a    = sample_addr;
        if (done) done_cnt++;
    endtask

    task automatic adv();
        @(posedge clk_30M);
        #1;
        sample_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // --------------------------------------------------------------- memory
    task automatic fill_mem(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0: mem[i] = i[DATA_W-1:0];
                1: mem[i] = (i == 3) ? 8'd200 : ((i == 300) ? 8'd120 : 8'd0);
                2: mem[i] = 8'd10;
                3: mem[i] = 8'($urandom_range(0, 255));
                default: mem[i] = 8'($urandom_range(0, 63));
            endcase
        end
    endtask

    // Reference model: results from the buffer contents directly.
    task automatic model(input logic [DATA_W-1:0] th, output logic [31:0] ef,
                         output logic [31:0] ea, output logic [31:0] pv, output logic [31:0] pa);
        ef = 0; ea = 0; pv = 32'(mem[0]); pa = 0;
        for (int i = 1; i < DEPTH; i++) begin
            if (32'(mem[i]) > pv) begin pv = 32'(mem[i]); pa = i; end
        end
        for (int i = BLANK; i < DEPTH; i++) begin
            if (mem[i] >= th) begin ef = 1; ea = i; break; end
        end
    endtask

    // ----------------------------------------------------------------- pass
    task automatic run_pass(input logic [DATA_W-1:0] th, input bit inj, input bit tim,
                            input logic [31:0] ef, input logic [31:0] ea,
                            input logic [31:0] pv, input logic [31:0] pa);
        int cycles, first_v, done0;
        bit injected, finished;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), mem[i]});
        seen = 0; hold_prev = 0; done0 = done_cnt;
        adv();
        start = 1'b1; thresh = th;
        adv();
        start = 1'b0;
        thresh = 8'($urandom_range(0, 255));  // latched copy must be used
        cycles = 1; first_v = 0; injected = 0; finished = 0;
        while (!finished) begin
            @(negedge clk_30M);
            monitor();
            if (sample_valid && first_v == 0) first_v = cycles;
            if (done) begin
                finished = 1;
            end else if (cycles > LIMIT) begin
                n_vec++; n_err++;
                $display("FAIL pass_timeout: got no done after %0d cycles, required done", cycles);
                finished = 1;
            end else begin
                adv();
                cycles++;
                start = 1'b0;
                if (inj && !injected && seen >= 20) begin
                    start = 1'b1; thresh = 8'd5; injected = 1;
                end
            end
        end
        chk("echo_found", 32'(echo_found), ef);
        chk("echo_addr", 32'(echo_addr), ea);
        chk("peak_val", 32'(peak_val), pv);
        chk("peak_addr", 32'(peak_addr), pa);
        if (tim) begin
            chk("done_latency", 32'(cycles), 32'(DEPTH * (RD_LAT + 2) + 1));
            chk("first_valid_latency", 32'(first_v), 32'(RD_LAT + 2));
        end
        // start in the same cycle as done must be dropped
        start = 1'b1; thresh = 8'd0;
        adv();
        start = 1'b0;
        @(negedge clk_30M);
        monitor();
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_pulse_width", 32'(done), 32'd0);
        repeat (3) begin adv(); @(negedge clk_30M); monitor(); end
        chk("done_count", 32'(done_cnt - done0), 32'd1);
        chk("sample_count", 32'(seen), 32'(DEPTH));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("echo_addr_hold", 32'(echo_addr), ea);
        chk("peak_val_hold", 32'(peak_val), pv);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_rd_en"}, 32'(ram_rd_en), 0);
        chk({tag, "_addr_rd"}, 32'(addr_rd), 0);
        chk({tag, "_sample_out"}, 32'(sample_out), 0);
        chk({tag, "_sample_addr"}, 32'(sample_addr), 0);
        chk({tag, "_sample_valid"}, 32'(sample_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_echo_found"}, 32'(echo_found), 0);
        chk({tag, "_echo_addr"}, 32'(echo_addr), 0);
        chk({tag, "_peak_val"}, 32'(peak_val), 0);
        chk({tag, "_peak_addr"}, 32'(peak_addr), 0);
        chk({tag, "_fsm_state"}, 32'(fsm_state), 0);
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        int              kind;
        logic [7:0]      th;
        int              rdy;
        bit              inj;
        bit              tim;
        bit              use_model;
        logic [31:0]     ef, ea, pv, pa;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [31:0] ef, ea, pv, pa;
        int guard, done0, busy_hi;

        //       kind  th  rdy inj tim model ef  ea   pv   pa
        vt[0] = '{0,   50,  0,  0,  1,  0,   1,  50, 255, 255};
        vt[1] = '{1,  100,  0,  0,  0,  0,   1, 300, 200,   3};
        vt[2] = '{2,   11,  1,  0,  0,  0,   0,   0,  10,   0};
        vt[3] = '{0,   50,  1,  1,  0,  0,   1,  50, 255, 255};
        vt[4] = '{0,    0,  0,  0,  1,  0,   1,   8, 255, 255};
        vt[5] = '{3, 8'($urandom_range(150, 255)), 1, 0, 0, 1, 0, 0, 0, 0};
        vt[6] = '{4, 8'($urandom_range(0, 70)),    1, 0, 0, 1, 0, 0, 0, 0};

        // reset state
        #12;
        chk_all_zero("reset");
        @(posedge clk_30M); #1;
        sys_rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            fill_mem(vt[v].kind);
            rdy_mode = vt[v].rdy;
            if (vt[v].use_model) model(vt[v].th, ef, ea, pv, pa);
            else begin ef = vt[v].ef; ea = vt[v].ea; pv = vt[v].pv; pa = vt[v].pa; end
            run_pass(vt[v].th, vt[v].inj, vt[v].tim, ef, ea, pv, pa);
        end

        // reset in the middle of a pass
        fill_mem(0);
        rdy_mode = 0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), mem[i]});
        seen = 0; hold_prev = 0;
        adv(); start = 1'b1; thresh = 8'd50;
        adv(); start = 1'b0;
        guard = 0;
        while (seen < 100 && guard < LIMIT) begin
            @(negedge clk_30M);
            monitor();
            if (seen < 100) adv();
            guard++;
        end
        chk("reset_reach_sample_100", 32'(seen >= 100), 32'd1);
        @(posedge clk_30M); #1;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(posedge clk_30M);
        #1;
        sys_rst_n = 1'b1;
        exp_q.delete();
        done0 = 0; busy_hi = 0;
        repeat (20) begin
            @(negedge clk_30M);
            if (done) done0++;
            if (busy) busy_hi++;
        end
        chk("post_reset_done", 32'(done0), 32'd0);
        chk("post_reset_busy", 32'(busy_hi), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
